exp4_fluxo_dados: RTL and testbench

Datapath for the Experiment 4 sequencer; the controlled end of the zeraC/contaC/zeraR/registraR/fimC control interface. It holds the address counter, the switch-input register, a fixed 16x4 pattern ROM, the comparator and a match accumulator. The control unit strobes it one command per cycle and reads back fimC to terminate its loop. The comparison flags and debug buses go to the board LEDs and displays.

---
 rtl/exp4_pkg.sv | 20 ++
 rtl/exp4_fluxo_dados_contador_m.sv | 37 +++
 rtl/exp4_fluxo_dados.sv | 103 ++++++++++
 tb/tb_exp4_fluxo_dados.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exp4_pkg.sv
// Shared definitions for the Experiment 4 datapath: default sizes, the
// pattern ROM contents and the comparator result encoding.
package exp4_pkg;

    localparam int N = 4;   // width of switches, register and ROM words
    localparam int M = 16;  // counter modulus and ROM depth (2**N)

    // Comparator outcome of register vs. ROM word; exactly one holds at a time.
    typedef enum logic [1:0] {
        CMP_MENOR = 2'd0,
        CMP_IGUAL = 2'd1,
        CMP_MAIOR = 2'd2
    } cmp_e;

    // Pattern ROM word at address i for an n-bit word: (3*i + 1) mod 2^n.
    function automatic int rom_init(input int i, input int n);
        return (3 * i + 1) % (1 << n);
    endfunction

endpackage

// File: rtl/exp4_fluxo_dados_contador_m.sv
// Modulus-M up counter with synchronous clear, count enable, terminal-count
// flag and asynchronous active-low reset.
module contador_m #(
    parameter int M = 16,
    parameter int W = $clog2(M)
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         zera,
    input  logic         conta,
    output logic [W-1:0] Q,
    output logic         fim
);

    logic [W-1:0] r_q;

    // Count register: clear wins over count, wraps from M-1 back to 0.
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_q <= '0;
        end else if (zera) begin
            r_q <= '0;
        end else if (conta) begin
            if (r_q == W'(M - 1)) begin
                r_q <= '0;
            end else begin
                r_q <= r_q + W'(1);
            end
        end
    end

    assign Q   = r_q;
    assign fim = (r_q == W'(M - 1));

endmodule

// File: rtl/exp4_fluxo_dados.sv
// Experiment 4 datapath: address counter, switch register, 16x4 pattern ROM,
// magnitude comparator and a saturating match accumulator driven by the
// zeraC/contaC/zeraR/registraR command strobes.
module exp4_fluxo_dados
    import exp4_pkg::*;
#(
    parameter int N = exp4_pkg::N,
    parameter int M = exp4_pkg::M
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         zeraC,
    input  logic         contaC,
    input  logic         zeraR,
    input  logic         registraR,
    input  logic [N-1:0] chaves,
    output logic         fimC,
    output logic         igual,
    output logic         menor,
    output logic         maior,
    output logic [N:0]   acertos,
    output logic [N-1:0] db_contagem,
    output logic [N-1:0] db_memoria,
    output logic [N-1:0] db_chaves
);

    logic [N-1:0] w_addr;
    logic [N-1:0] w_rom_word;
    logic         w_fim;
    cmp_e         w_cmp;

    logic [N-1:0] r_chaves;
    logic         r_pending;
    logic [N:0]   r_acertos;

    // Address counter sweeping the ROM.
    contador_m #(
        .M (M),
        .W (N)
    ) u_contador (
        .clock (clock),
        .reset (reset),
        .zera  (zeraC),
        .conta (contaC),
        .Q     (w_addr),
        .fim   (w_fim)
    );

    // Switch register: clear wins over load, otherwise hold.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_chaves <= '0;
        end else if (zeraR) begin
            r_chaves <= '0;
        end else if (registraR) begin
            r_chaves <= chaves;
        end
    end

    // Pattern ROM, purely combinational on the address.
    always_comb begin
        w_rom_word = N'(rom_init(int'(w_addr), N));
    end

    // Magnitude comparator of register vs. ROM word (unsigned).
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        w_cmp = CMP_IGUAL;
        if (r_chaves < w_rom_word) begin
            w_cmp = CMP_MENOR;
        end else if (r_chaves > w_rom_word) begin
            w_cmp = CMP_MAIOR;
        end
    end

    // Match accumulator: a load marks the value pending, the following edge
    // counts it if it matched; saturates at M, cleared together with the register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_pending <= 1'b0;
            r_acertos <= '0;
        end else if (zeraR) begin
            r_pending <= 1'b0;
            r_acertos <= '0;
        end else begin
            r_pending <= registraR;
            if (r_pending && (w_cmp == CMP_IGUAL) && (r_acertos != (N+1)'(M))) begin
                r_acertos <= r_acertos + (N+1)'(1);
            end
        end
    end

    assign fimC        = w_fim;
    assign igual       = (w_cmp == CMP_IGUAL);
    assign menor       = (w_cmp == CMP_MENOR);
    assign maior       = (w_cmp == CMP_MAIOR);
    assign acertos     = r_acertos;
    assign db_contagem = w_addr;
    assign db_memoria  = w_rom_word;
    assign db_chaves   = r_chaves;

endmodule

// File: tb/tb_exp4_fluxo_dados.sv
// Directed self-checking bench for exp4_fluxo_dados.
module tb_exp4_fluxo_dados;

    logic       clock;
    logic       reset;
    logic       zeraC;
    logic       contaC;
    logic       zeraR;
    logic       registraR;
    logic [3:0] chaves;
    logic       fimC;
    logic       igual;
    logic       menor;
    logic       maior;
    logic [4:0] acertos;
    logic [3:0] db_contagem;
    logic [3:0] db_memoria;
    logic [3:0] db_chaves;

    int n_vec = 0;
    int n_err = 0;

    // Hand-written pattern ROM contents, addresses 0..F.
    logic [3:0] rom_tbl [16];

    exp4_fluxo_dados dut (
        .clock       (clock),
        .reset       (reset),
        .zeraC       (zeraC),
        .contaC      (contaC),
        .zeraR       (zeraR),
        .registraR   (registraR),
        .chaves      (chaves),
        .fimC        (fimC),
        .igual       (igual),
        .menor       (menor),
        .maior       (maior),
        .acertos     (acertos),
        .db_contagem (db_contagem),
        .db_memoria  (db_memoria),
        .db_chaves   (db_chaves)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // One clock edge, then settle 1 time unit past it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        zeraC = 1'b0; contaC = 1'b0; zeraR = 1'b0; registraR = 1'b0;
    endtask

    task automatic test_reset();
        // Build counter=5, acertos=3 at address 0 (ROM=1).
        idle();
        chaves = 4'h1; registraR = 1'b1;
        repeat (3) tick();
        idle();
        tick();
        contaC = 1'b1;
        repeat (5) tick();
        idle();
        n_vec++;
        if ({db_contagem, acertos} !== {4'd5, 5'd3}) begin
            $display("FAIL reset_setup cnt/acertos got %h/%0d want 5/3", db_contagem, acertos);
            n_err++;
        end
        // Asynchronous reset mid-cycle, away from any edge.
        contaC = 1'b1; registraR = 1'b1; chaves = 4'h7;
        #2 reset = 1'b0;
        #1;
        n_vec++;
        if ({db_contagem, acertos, db_chaves} !== {4'd0, 5'd0, 4'd0}) begin
            $display("FAIL reset_state cnt/acertos/chaves got %h/%0d/%h want 0/0/0",
                     db_contagem, acertos, db_chaves);
            n_err++;
        end
        n_vec++;
        if ({db_memoria, fimC, igual, menor, maior} !== {4'h1, 1'b0, 1'b0, 1'b1, 1'b0}) begin
            $display("FAIL reset_flags mem/fim/ig/me/ma got %h/%b%b%b%b want 1/0010",
                     db_memoria, fimC, igual, menor, maior);
            n_err++;
        end
        // Commands are still asserted while held in reset: state must not move.
        tick();
        n_vec++;
        if ({db_contagem, acertos, db_chaves} !== {4'd0, 5'd0, 4'd0}) begin
            $display("FAIL reset_hold cnt/acertos/chaves got %h/%0d/%h want 0/0/0",
                     db_contagem, acertos, db_chaves);
            n_err++;
        end
        idle();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_counter_wrap();
        contaC = 1'b1;
        repeat (15) tick();
        contaC = 1'b0;
        n_vec++;
        if ({db_contagem, fimC, db_memoria} !== {4'hF, 1'b1, 4'hE}) begin
            $display("FAIL count_terminal cnt/fim/mem got %h/%b/%h want F/1/E",
                     db_contagem, fimC, db_memoria);
            n_err++;
        end
        contaC = 1'b1;
        tick();
        contaC = 1'b0;
        n_vec++;
        if ({db_contagem, fimC, db_memoria} !== {4'h0, 1'b0, 4'h1}) begin
            $display("FAIL count_wrap cnt/fim/mem got %h/%b/%h want 0/0/1",
                     db_contagem, fimC, db_memoria);
            n_err++;
        end
        tick();
        n_vec++;
        if (db_contagem !== 4'h0) begin
            $display("FAIL count_hold cnt got %h want 0", db_contagem);
            n_err++;
        end
    endtask

    task automatic test_priority();
        contaC = 1'b1;
        repeat (7) tick();
        contaC = 1'b0;
        n_vec++;
        if (db_contagem !== 4'h7) begin
            $display("FAIL prio_setup cnt got %h want 7", db_contagem);
            n_err++;
        end
        zeraC = 1'b1; contaC = 1'b1;
        tick();
        idle();
        n_vec++;
        if (db_contagem !== 4'h0) begin
            $display("FAIL zeraC_over_contaC cnt got %h want 0", db_contagem);
            n_err++;
        end
        chaves = 4'h3; registraR = 1'b1;
        tick();
        idle();
        n_vec++;
        if (db_chaves !== 4'h3) begin
            $display("FAIL load chaves got %h want 3", db_chaves);
            n_err++;
        end
        chaves = 4'h9; zeraR = 1'b1; registraR = 1'b1;
        tick();
        idle();
        n_vec++;
        if (db_chaves !== 4'h0) begin
            $display("FAIL zeraR_over_registraR chaves got %h want 0", db_chaves);
            n_err++;
        end
    endtask

    task automatic test_compare();
        // Address 3 (ROM=A), accumulator cleared.
        zeraC = 1'b1; zeraR = 1'b1;
        tick();
        idle();
        contaC = 1'b1;
        repeat (3) tick();
        idle();
        n_vec++;
        if ({db_contagem, db_memoria, acertos} !== {4'h3, 4'hA, 5'd0}) begin
            $display("FAIL cmp_setup cnt/mem/acertos got %h/%h/%0d want 3/A/0",
                     db_contagem, db_memoria, acertos);
            n_err++;
        end
        // Match.
        chaves = 4'hA; registraR = 1'b1;
        tick();
        idle();
        n_vec++;
        if ({igual, menor, maior, acertos} !== {3'b100, 5'd0}) begin
            $display("FAIL cmp_equal ig/me/ma/acertos got %b%b%b/%0d want 100/0",
                     igual, menor, maior, acertos);
            n_err++;
        end
        tick();
        n_vec++;
        if (acertos !== 5'd1) begin
            $display("FAIL cmp_equal_acc acertos got %0d want 1", acertos);
            n_err++;
        end
        // Less than.
        chaves = 4'h5; registraR = 1'b1;
        tick();
        idle();
        n_vec++;
        if ({igual, menor, maior} !== 3'b010) begin
            $display("FAIL cmp_less ig/me/ma got %b%b%b want 010", igual, menor, maior);
            n_err++;
        end
        tick();
        n_vec++;
        if (acertos !== 5'd1) begin
            $display("FAIL cmp_less_acc acertos got %0d want 1", acertos);
            n_err++;
        end
        // Greater than.
        chaves = 4'hC; registraR = 1'b1;
        tick();
        idle();
        n_vec++;
        if ({igual, menor, maior} !== 3'b001) begin
            $display("FAIL cmp_greater ig/me/ma got %b%b%b want 001", igual, menor, maior);
            n_err++;
        end
        tick();
        n_vec++;
        if (acertos !== 5'd1) begin
            $display("FAIL cmp_greater_acc acertos got %0d want 1", acertos);
            n_err++;
        end
    endtask

    // registra / comparacao / proximo cadence across all 16 addresses.
    task automatic sweep(input bit do_check);
        for (int i = 0; i < 16; i++) begin
            chaves = rom_tbl[i]; registraR = 1'b1;
            tick();
            idle();
            if (do_check) begin
                n_vec++;
                if ({igual, fimC} !== {1'b1, (i == 15)}) begin
                    $display("FAIL sweep_cmp addr %0d ig/fim got %b/%b want 1/%b",
                             i, igual, fimC, (i == 15));
                    n_err++;
                end
            end
            tick();
            contaC = 1'b1;
            tick();
            contaC = 1'b0;
        end
    endtask

    task automatic test_sweep();
        zeraC = 1'b1; zeraR = 1'b1;
        tick();
        idle();
        sweep(1'b1);
        n_vec++;
        if ({acertos, db_contagem} !== {5'd16, 4'h0}) begin
            $display("FAIL sweep_total acertos/cnt got %0d/%h want 16/0", acertos, db_contagem);
            n_err++;
        end
        sweep(1'b0);
        n_vec++;
        if (acertos !== 5'd16) begin
            $display("FAIL sweep_saturate acertos got %0d want 16", acertos);
            n_err++;
        end
    endtask

    task automatic test_back_to_back();
        // Address 0 (ROM=1), accumulator cleared.
        zeraC = 1'b1; zeraR = 1'b1;
        tick();
        idle();
        chaves = 4'h1; registraR = 1'b1;
        tick();
        chaves = 4'h2;
        tick();
        idle();
        n_vec++;
        if ({acertos, menor} !== {5'd1, 1'b0} || maior !== 1'b1) begin
            $display("FAIL b2b_first acertos/me/ma got %0d/%b/%b want 1/0/1", acertos, menor, maior);
            n_err++;
        end
        tick();
        n_vec++;
        if (acertos !== 5'd1) begin
            $display("FAIL b2b_second acertos got %0d want 1", acertos);
            n_err++;
        end
        // Matching load, then zeraR in the accumulate cycle.
        chaves = 4'h1; registraR = 1'b1;
        tick();
        idle();
        zeraR = 1'b1;
        tick();
        idle();
        n_vec++;
        if ({acertos, db_chaves} !== {5'd0, 4'h0}) begin
            $display("FAIL zeraR_over_acc acertos/chaves got %0d/%h want 0/0", acertos, db_chaves);
            n_err++;
        end
        tick();
        n_vec++;
        if (acertos !== 5'd0) begin
            $display("FAIL zeraR_pending_cleared acertos got %0d want 0", acertos);
            n_err++;
        end
    endtask

    initial begin
        rom_tbl[0]  = 4'h1; rom_tbl[1]  = 4'h4; rom_tbl[2]  = 4'h7; rom_tbl[3]  = 4'hA;
        rom_tbl[4]  = 4'hD; rom_tbl[5]  = 4'h0; rom_tbl[6]  = 4'h3; rom_tbl[7]  = 4'h6;
        rom_tbl[8]  = 4'h9; rom_tbl[9]  = 4'hC; rom_tbl[10] = 4'hF; rom_tbl[11] = 4'h2;
        rom_tbl[12] = 4'h5; rom_tbl[13] = 4'h8; rom_tbl[14] = 4'hB; rom_tbl[15] = 4'hE;
        idle();
        chaves = 4'h0;
        reset  = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        tick();

        test_reset();
        test_counter_wrap();
        test_priority();
        test_compare();
        test_sweep();
        test_back_to_back();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
